// File: rtl/stim_gen.sv
// Multi-channel square-wave / counter stimulus generator with a timed run.
// Define STIM_GEN_COUNT_EN to add the mode port and binary-count mode.
module stim_gen #(
  parameter int CH    = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [CH*CNT_W-1:0] period,
  input  logic [LEN_W-1:0]    run_len,
  input  logic [CH-1:0]       init,
`ifdef STIM_GEN_COUNT_EN
  input  logic                mode,
`endif
  output logic [CH-1:0]       stim,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    cyc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CH-1:0]            stim_q, stim_d;
  logic [LEN_W-1:0]         cyc_q, cyc_d;
  logic [LEN_W-1:0]         cyc_nxt;
  logic [LEN_W-1:0]         run_len_q, run_len_d;
  logic [CH*CNT_W-1:0]      period_q, period_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [CH-1:0]            wrap;
`ifdef STIM_GEN_COUNT_EN
  logic                     mode_q, mode_d;
`endif

  // Counter i wraps on edges whose index is a multiple of its period.
  always_comb begin
    wrap    = '0;
    cnt_nxt = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (period_q[i*CNT_W +: CNT_W] == '0) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] ==
                   period_q[i*CNT_W +: CNT_W] - 1'b1) begin
        wrap[i]    = 1'b1;
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign cyc_nxt = cyc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    cyc_d     = cyc_q;
    run_len_d = run_len_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
`ifdef STIM_GEN_COUNT_EN
    mode_d    = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          period_d  = period;
          run_len_d = run_len;
          stim_d    = init;
          cyc_d     = '0;
          cnt_d     = '0;
`ifdef STIM_GEN_COUNT_EN
          mode_d    = mode;
`endif
          state_d   = (run_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DONE;
        end else begin
          cyc_d  = cyc_nxt;
          cnt_d  = cnt_nxt;
`ifdef STIM_GEN_COUNT_EN
          if (mode_q) stim_d = stim_q + CH'(wrap[0]);
          else        stim_d = stim_q ^ wrap;
`else
          stim_d = stim_q ^ wrap;
`endif
          if (cyc_nxt == run_len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      cyc_q     <= '0;
      run_len_q <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
`ifdef STIM_GEN_COUNT_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      cyc_q     <= cyc_d;
      run_len_q <= run_len_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
`ifdef STIM_GEN_COUNT_EN
      mode_q    <= mode_d;
`endif
    end
  end

  assign stim = stim_q;
  assign cyc  = cyc_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: driver queues per-edge expectations
// from a closed-form model, monitor compares after every clock edge.
module tb_stim_gen;
  localparam int CH    = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                stop = 1'b0;
  logic [CH*CNT_W-1:0] period = '0;
  logic [LEN_W-1:0]    run_len = '0;
  logic [CH-1:0]       init = '0;
`ifdef STIM_GEN_COUNT_EN
  logic                mode = 1'b0;
`endif
  logic [CH-1:0]       stim;
  logic                busy;
  logic                done;
  logic [LEN_W-1:0]    cyc;

  stim_gen #(.CH(CH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .period(period),
    .run_len(run_len),
    .init(init),
`ifdef STIM_GEN_COUNT_EN
    .mode(mode),
`endif
    .stim(stim),
    .busy(busy),
    .done(done),
    .cyc(cyc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    stim;
    logic [LEN_W-1:0] cyc;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Level after k run edges, straight from the toggle/count rules.
  function automatic logic [CH-1:0] model(
      input logic [CH*CNT_W-1:0] p, input logic [CH-1:0] ini,
      input logic md, input int k);
    logic [CH-1:0] r;
    int s;
    int pi;
    r = ini;
    if (md) begin
      pi = int'(p[CNT_W-1:0]);
      s  = int'(ini) + ((pi == 0) ? 0 : k / pi);
      r  = s[CH-1:0];
    end else begin
      for (int i = 0; i < CH; i++) begin
        pi = int'(p[i*CNT_W +: CNT_W]);
        if (pi != 0 && ((k / pi) % 2) == 1) r[i] = ~ini[i];
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [CH-1:0] s, input int c,
                              input logic b, input logic d);
    exp_t e;
    e.stim = s;
    e.cyc  = c[LEN_W-1:0];
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stim", 32'(stim), 32'(e.stim));
        chk("cyc", 32'(cyc), 32'(e.cyc));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
      end else begin
        chk("idle_done", 32'(done), 32'd0);
      end
    end
  end

  task automatic set_cfg(input logic [CH*CNT_W-1:0] p, input int l,
                         input logic [CH-1:0] ini, input logic md);
    period  = p;
    run_len = l[LEN_W-1:0];
    init    = ini;
`ifdef STIM_GEN_COUNT_EN
    mode    = md;
`endif
  endtask

  task automatic run(input logic [CH*CNT_W-1:0] p, input int l,
                     input logic [CH-1:0] ini, input logic md,
                     input int stop_at, input bit scramble);
    int r;
    int v;
    r = (stop_at > 0) ? stop_at : l;
    v = (stop_at > 0) ? stop_at - 1 : l;
    @(negedge clk);
    set_cfg(p, l, ini, md);
    start = 1'b1;
    for (int k = 0; k < r; k++) q.push_back(mk(model(p, ini, md, k), k, 1'b1, 1'b0));
    q.push_back(mk(model(p, ini, md, v), v, 1'b1, 1'b1));
    q.push_back(mk(model(p, ini, md, v), v, 1'b0, 1'b0));
    for (int e = 0; e < r + 2; e++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (stop_at > 0 && e + 1 == stop_at);
      if (scramble && e < r) begin
        set_cfg(CH*CNT_W'($urandom()), int'($urandom_range(0, 200)),
                CH'($urandom()), 1'($urandom()));
        start = 1'b1;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  localparam logic [CH*CNT_W-1:0] P7532 = {8'd7, 8'd5, 8'd3, 8'd2};

  initial begin
    logic [CH*CNT_W-1:0] rp;
    int rl;
    int rs;
    logic rm;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(P7532, 56, 4'b0000, 1'b0, 0, 1'b0);
    chk("r18_stim", 32'(stim), 32'h4);
    chk("r18_cyc", 32'(cyc), 32'd56);

    run({8'd1, 8'd1, 8'd0, 8'd1}, 5, 4'b0010, 1'b0, 0, 1'b0);
    chk("r19_ch1", 32'(stim[1]), 32'd1);

    run(P7532, 100, 4'b1001, 1'b0, 10, 1'b0);
    chk("r20_cyc", 32'(cyc), 32'd9);

    run(P7532, 0, 4'b1010, 1'b0, 0, 1'b0);
    run(P7532, 30, 4'b0110, 1'b0, 0, 1'b1);
    run(P7532, 12, 4'b0000, 1'b0, 12, 1'b0);
    run({8'd0, 8'd0, 8'd0, 8'd1}, 1, 4'b0101, 1'b0, 0, 1'b0);

    // Reset pulled low just before E20 of a 56-edge run.
    @(negedge clk);
    set_cfg(P7532, 56, 4'b0011, 1'b0);
    start = 1'b1;
    for (int k = 0; k < 20; k++) q.push_back(mk(model(P7532, 4'b0011, 1'b0, k), k, 1'b1, 1'b0));
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("r22_stim", 32'(stim), 32'd0);
    chk("r22_busy", 32'(busy), 32'd0);
    chk("r22_cyc", 32'(cyc), 32'd0);
    chk("r22_done", 32'(done), 32'd0);
    chk("r22_drain", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(P7532, 56, 4'b0000, 1'b0, 0, 1'b0);

`ifdef STIM_GEN_COUNT_EN
    run({8'd0, 8'd0, 8'd0, 8'd1}, 16, 4'b0000, 1'b1, 0, 1'b0);
    chk("r23_stim", 32'(stim), 32'd0);
    run({8'd3, 8'd1, 8'd0, 8'd0}, 9, 4'b0111, 1'b1, 0, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < CH; i++) rp[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
      rl = int'($urandom_range(0, 40));
      rs = ($urandom_range(0, 3) == 0 && rl > 0) ? int'($urandom_range(1, rl)) : 0;
`ifdef STIM_GEN_COUNT_EN
      rm = 1'($urandom());
`else
      rm = 1'b0;
`endif
      run(rp, rl, CH'($urandom()), rm, rs, 1'($urandom()));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
